i2c_reg_access_ctrl: RTL
========================

Name: i2c_reg_access_ctrl

Overview:
- Wishbone-master sequencer that drives the 8-bit Wishbone I2C master core (registers PRERlo/PRERhi/CTR/TXR-RXR/CR-SR at addresses 0-4).
- After reset it programs the prescaler and enables the core.
- It then turns single requests (7-bit device, 8-bit register, read/write one byte) into the full START/address/data/STOP register-access sequence.
- It returns the read data, or an error code for NACK, arbitration loss or timeout.

Parameters:
- PRESCALE, 16'd99, value written to PRERhi:PRERlo during init.
- POLL_LIMIT, 1024, maximum SR reads per TIP poll before timeout.

Ports:
- WB_CLK_I  in  1  system clock; all logic on rising edge.
- ARST_I  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and initialised.
- req_rnw  in  1  1 = read, 0 = write.
- req_dev_addr  in  7  I2C device address.
- req_reg_addr  in  8  target register address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; valid with rsp_valid for an OK read; 0 otherwise.
- rsp_err  out  2  00 OK, 01 NACK, 10 arbitration lost, 11 timeout.
- wbm_adr_o  out  3  core register address.
- wbm_dat_o  out  8  write data to core.
- wbm_dat_i  in  8  read data from core.
- wbm_we_o  out  1  write enable.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_ack_i  in  1  core acknowledge.

Behaviour:
- Reset values (ARST_I low): all outputs 0, step counter 0, poll counter 0, FSM in INIT. A reset mid-transaction aborts it with no response, and init re-runs after release.
- Wishbone access:
  - cyc = stb = 1 with adr/dat/we stable until the cycle wbm_ack_i = 1 is sampled.
  - cyc/stb drop on the next edge.
  - At least one idle cycle separates accesses.
  - No ack ever arrives: the bus wait is unbounded.
- INIT:
  - Write addr0 = PRESCALE[7:0], then addr1 = PRESCALE[15:8], then addr2 = 0x80 (EN = 1, IEN = 0), then go to IDLE.
  - req_ready is 0 throughout INIT.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture all req_* fields; req_ready drops the next cycle and stays 0 until the response cycle has passed.
- Step list. W(a, d) is a write; P is a TIP poll.
  - Write request: W(3, {dev,0}), W(4, 0x90), P, W(3, reg), W(4, 0x10), P, W(3, wdata), W(4, 0x50), P.
  - Read request: W(3, {dev,0}), W(4, 0x90), P, W(3, reg), W(4, 0x10), P, W(3, {dev,1}), W(4, 0x90), P, W(4, 0x68), P, then read addr3 into rsp_rdata.
- POLL:
  - Repeated reads of addr4 (SR) until SR[1] (TIP) = 0.
  - Each read increments the poll counter; the counter is cleared at every poll entry.
  - Counter reaching POLL_LIMIT with TIP still 1 is a timeout: W(4, 0x40) with no poll, then respond err 11.
- Post-poll checks, in priority order:
  - SR[5] (AL) = 1: respond err 10 immediately, no STOP written.
  - Else SR[7] (RxACK) = 1 on any poll except the poll after 0x68: W(4, 0x40), poll TIP, respond err 01. If that poll also times out, respond err 11.
  - Else continue with the next step.
- RESP:
  - rsp_valid high for exactly one cycle, with rsp_err and rsp_rdata.
  - Return to IDLE; req_ready is 1 on the following cycle.
  - There is no back-pressure on responses.
- req_valid while busy is ignored; the request remains pending on the input.

Test Plan:
- Reset release, ack always 1 cycle late → bus writes (0, 0x63), (1, 0x00), (2, 0x80) in order; req_ready rises only after the third ack.
- Write dev = 0x50, reg = 0x12, data = 0xA5; SR model returns TIP = 1 twice then 0, RxACK = 0 → TXR writes 0xA0, 0x12, 0xA5; CR writes 0x90, 0x10, 0x50; rsp_valid pulse with err 00.
- Read dev = 0x50, reg = 0x34; RXR model = 0x5C → TXR writes 0xA0, 0x34, 0xA1; CR writes 0x90, 0x10, 0x90, 0x68; rsp_rdata = 0x5C, err 00.
- Address NACK: SR = 0x80 after the first poll → CR write 0x40 follows; response err 01; no data byte written.
- AL = 1 after the second poll → no further writes; err 10. Then with POLL_LIMIT = 4 and TIP stuck at 1 → exactly 4 SR reads, CR 0x40 written, err 11.
- ARST_I asserted mid-read → all outputs 0 immediately; after release the init sequence repeats and no rsp_valid is emitted for the aborted request.

Source files
------------

// File: rtl/i2c_reg_access_ctrl.sv
// i2c_reg_access_ctrl
//   Wishbone master that sequences the 8-bit I2C master core.
//   After reset it writes the prescaler and enables the core.
//   It then runs single-byte register reads and writes on an I2C device:
//   START, address, register, optional repeated START, data, and STOP.
//   Every byte transfer is followed by a TIP poll of SR.
//   The result is one response pulse carrying read data or an error code.
// Ports
//   WB_CLK_I, ARST_I    clock; asynchronous active-low reset
//   req_*               request handshake; fields captured on acceptance
//   rsp_*               one-cycle response: rdata, err (00 ok, 01 nack,
//                       10 arbitration lost, 11 timeout)
//   wbm_*               Wishbone master port to the core (adr 0..4)
module i2c_reg_access_ctrl #(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic       WB_CLK_I,
    input  logic       ARST_I,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    localparam int unsigned CW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_NEXT, S_BUS, S_RESP} state_t;
    // M_STOPW/M_STOPP: STOP write then poll after a NACK; M_TOW: STOP after timeout
    typedef enum logic [2:0] {M_INIT, M_REQ, M_STOPW, M_STOPP, M_TOW} mode_t;
    typedef enum logic [1:0] {K_WR, K_POLL, K_RDRX, K_DONE} kind_t;

    state_t        r_state, w_state;
    mode_t         r_mode, w_mode;
    logic [3:0]    r_step, w_step;
    logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic          r_rnw, w_rnw;
    logic [6:0]    r_dev, w_dev;
    logic [7:0]    r_reg, w_reg, r_wdata, w_wdata;
    logic          r_ready, w_ready, r_rsp_valid, w_rsp_valid;
    logic [7:0]    r_rsp_rdata, w_rsp_rdata;
    logic [1:0]    r_rsp_err, w_rsp_err;
    logic          r_cyc, w_cyc, r_we, w_we;
    logic [2:0]    r_adr, w_adr;
    logic [7:0]    r_dat, w_dat;
    kind_t         w_kind;
    logic [2:0]    w_sadr;
    logic [7:0]    w_sdat;
    logic          w_last;

    assign w_cnt_inc = r_cnt + CW'(1);
    // The poll after the final 0x68 command expects NACK from the master side
    assign w_last    = r_rnw && (r_step == 4'd10);

    // Action for the current mode/step: write, SR poll, RXR read, or done
    always_comb begin
        w_kind = K_DONE;
        w_sadr = 3'd4;
        w_sdat = '0;
        case (r_mode)
            M_INIT: begin
                w_kind = K_WR;
                case (r_step)
                    4'd0:    begin w_sadr = 3'd0; w_sdat = PRESCALE[7:0];  end
                    4'd1:    begin w_sadr = 3'd1; w_sdat = PRESCALE[15:8]; end
                    default: begin w_sadr = 3'd2; w_sdat = 8'h80;          end
                endcase
            end
            M_STOPW, M_TOW: begin w_kind = K_WR; w_sdat = 8'h40; end
            M_STOPP:        w_kind = K_POLL;
            default: begin
                case (r_step)
                    4'd0: begin w_kind = K_WR; w_sadr = 3'd3; w_sdat = {r_dev, 1'b0}; end
                    4'd1: begin w_kind = K_WR; w_sdat = 8'h90; end
                    4'd2: w_kind = K_POLL;
                    4'd3: begin w_kind = K_WR; w_sadr = 3'd3; w_sdat = r_reg; end
                    4'd4: begin w_kind = K_WR; w_sdat = 8'h10; end
                    4'd5: w_kind = K_POLL;
                    4'd6: begin
                        w_kind = K_WR;
                        w_sadr = 3'd3;
                        w_sdat = r_rnw ? {r_dev, 1'b1} : r_wdata;
                    end
                    4'd7: begin w_kind = K_WR; w_sdat = r_rnw ? 8'h90 : 8'h50; end
                    4'd8: w_kind = K_POLL;
                    4'd9: if (r_rnw) begin w_kind = K_WR; w_sdat = 8'h68; end
                    4'd10: if (r_rnw) w_kind = K_POLL;
                    4'd11: if (r_rnw) begin w_kind = K_RDRX; w_sadr = 3'd3; end
                    default: w_kind = K_DONE;
                endcase
            end
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_mode      = r_mode;
        w_step      = r_step;
        w_cnt       = r_cnt;
        w_rnw       = r_rnw;
        w_dev       = r_dev;
        w_reg       = r_reg;
        w_wdata     = r_wdata;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = '0;
        w_rsp_err   = '0;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_adr       = r_adr;
        w_dat       = r_dat;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_rnw   = req_rnw;
                    w_dev   = req_dev_addr;
                    w_reg   = req_reg_addr;
                    w_wdata = req_wdata;
                    w_step  = '0;
                    w_mode  = M_REQ;
                    w_state = S_NEXT;
                end else begin
                    w_ready = 1'b1;
                end
            end
            S_INIT, S_NEXT: begin
                if (w_kind == K_DONE) begin
                    w_state     = S_RESP;
                    w_rsp_valid = 1'b1;
                end else begin
                    w_cyc   = 1'b1;
                    w_we    = (w_kind == K_WR);
                    w_adr   = w_sadr;
                    w_dat   = (w_kind == K_WR) ? w_sdat : 8'h00;
                    w_state = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm_ack_i) begin
                    w_cyc   = 1'b0;
                    w_we    = 1'b0;
                    w_state = S_NEXT;
                    if (r_mode == M_INIT) begin
                        w_step = r_step + 4'd1;
                        if (r_step == 4'd2) begin
                            w_state = S_IDLE;
                            w_ready = 1'b1;
                        end else begin
                            w_state = S_INIT;
                        end
                    end else if (r_we) begin
                        // every poll follows a write, so clearing here starts each poll at zero
                        w_cnt = '0;
                        case (r_mode)
                            M_STOPW: w_mode = M_STOPP;
                            M_TOW: begin
                                w_state     = S_RESP;
                                w_rsp_valid = 1'b1;
                                w_rsp_err   = 2'b11;
                            end
                            default: w_step = r_step + 4'd1;
                        endcase
                    end else if (r_adr == 3'd3) begin
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = wbm_dat_i;
                    end else begin
                        w_cnt = w_cnt_inc;
                        if (wbm_dat_i[1]) begin
                            if (w_cnt_inc == CW'(POLL_LIMIT)) begin
                                if (r_mode == M_STOPP) begin
                                    w_state     = S_RESP;
                                    w_rsp_valid = 1'b1;
                                    w_rsp_err   = 2'b11;
                                end else begin
                                    w_mode = M_TOW;
                                end
                            end
                        end else if (r_mode == M_STOPP) begin
                            w_state     = S_RESP;
                            w_rsp_valid = 1'b1;
                            w_rsp_err   = 2'b01;
                        end else if (wbm_dat_i[5]) begin
                            w_state     = S_RESP;
                            w_rsp_valid = 1'b1;
                            w_rsp_err   = 2'b10;
                        end else if (wbm_dat_i[7] && !w_last) begin
                            w_mode = M_STOPW;
                        end else begin
                            w_step = r_step + 4'd1;
                        end
                    end
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
            end
            default: w_state = S_INIT;
        endcase
    end

    always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
        if (!ARST_I) begin
            r_state     <= S_INIT;
            r_mode      <= M_INIT;
            r_step      <= '0;
            r_cnt       <= '0;
            r_rnw       <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
        end else begin
            r_state     <= w_state;
            r_mode      <= w_mode;
            r_step      <= w_step;
            r_cnt       <= w_cnt;
            r_rnw       <= w_rnw;
            r_dev       <= w_dev;
            r_reg       <= w_reg;
            r_wdata     <= w_wdata;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_we_o  = r_we;
    assign wbm_stb_o = r_cyc;
    assign wbm_cyc_o = r_cyc;

endmodule
